// File: rtl/ddr3_phy_pkg.sv
// rtl/ddr3_phy_pkg.sv - shared DDR3 PHY write-path types and constants
package ddr3_phy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_PRE,
    ST_BURST,
    ST_POST
  } dqs_state_e;

  localparam int BL8_BEATS   = 8;
  localparam int BC4_BEATS   = 4;
  localparam int LAT_CNT_W   = 6;
  localparam int PHASE_CNT_W = 2;
  localparam int BEAT_CNT_W  = 3;

  function automatic logic [BEAT_CNT_W-1:0] last_beat(input logic bc4);
    return bc4 ? BEAT_CNT_W'(BC4_BEATS - 1) : BEAT_CNT_W'(BL8_BEATS - 1);
  endfunction

endpackage

// File: rtl/ddr3_dqs_tx_ctrl.sv
// rtl/ddr3_dqs_tx_ctrl.sv - DQS write-strobe sequencer: latency wait, preamble, burst, postamble
module ddr3_dqs_tx_ctrl
  import ddr3_phy_pkg::*;
#(
  parameter int WR_LAT_BEATS    = 10,
  parameter int PREAMBLE_BEATS  = 2,
  parameter int POSTAMBLE_BEATS = 1
) (
  input  logic i_ddr3_clk,
  input  logic i_rst_n,
  input  logic i_wr_valid,
  input  logic i_bc4,
  output logic o_wr_ready,
  output logic o_dqs,
  output logic o_dqs_t,
  output logic o_dq_t,
  output logic o_beat_first,
  output logic o_beat_last,
  output logic o_busy
);

  localparam logic [LAT_CNT_W-1:0]   LAT_LOAD = LAT_CNT_W'(WR_LAT_BEATS);
  localparam logic [PHASE_CNT_W-1:0] PRE_END  = PHASE_CNT_W'(PREAMBLE_BEATS - 1);
  localparam logic [PHASE_CNT_W-1:0] POST_END = PHASE_CNT_W'(POSTAMBLE_BEATS - 1);

  dqs_state_e             state, state_d;
  logic [LAT_CNT_W-1:0]   lat_cnt, lat_d;
  logic [PHASE_CNT_W-1:0] phase_cnt, phase_d;
  logic [BEAT_CNT_W-1:0]  beat_cnt, beat_d;
  logic                   bc4_q, bc4_d;
  logic                   ready_d, dqs_d, dqs_t_d, dq_t_d, first_d, last_d, busy_d;

  always_comb begin
    state_d = state;
    lat_d   = lat_cnt;
    phase_d = phase_cnt;
    beat_d  = beat_cnt;
    bc4_d   = bc4_q;

    case (state)
      ST_IDLE: begin
        if (i_wr_valid && o_wr_ready) begin
          bc4_d = i_bc4;
          if (WR_LAT_BEATS == 0) begin
            state_d = ST_PRE;
            phase_d = '0;
          end else begin
            state_d = ST_WAIT;
            lat_d   = LAT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        lat_d = lat_cnt - 6'd1;
        if (lat_cnt == 6'd1) begin
          state_d = ST_PRE;
          phase_d = '0;
        end
      end
      ST_PRE: begin
        if (phase_cnt == PRE_END) begin
          state_d = ST_BURST;
          beat_d  = '0;
        end else begin
          phase_d = phase_cnt + 2'd1;
        end
      end
      ST_BURST: begin
        // beat_cnt stops at len-1 so it never wraps
        if (beat_cnt == last_beat(bc4_q)) begin
          state_d = ST_POST;
          phase_d = '0;
        end else begin
          beat_d = beat_cnt + 3'd1;
        end
      end
      ST_POST: begin
        if (phase_cnt == POST_END) begin
          state_d = ST_IDLE;
        end else begin
          phase_d = phase_cnt + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so that they register in step with it
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    dqs_t_d = !((state_d == ST_PRE) || (state_d == ST_BURST) || (state_d == ST_POST));
    dq_t_d  = (state_d != ST_BURST);
    dqs_d   = (state_d == ST_BURST) && !beat_d[0];
    first_d = (state_d == ST_BURST) && (beat_d == '0);
    last_d  = (state_d == ST_BURST) && (beat_d == last_beat(bc4_d));
  end

  always_ff @(posedge i_ddr3_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      lat_cnt      <= '0;
      phase_cnt    <= '0;
      beat_cnt     <= '0;
      bc4_q        <= 1'b0;
      o_wr_ready   <= 1'b0;
      o_busy       <= 1'b0;
      o_dqs        <= 1'b0;
      o_dqs_t      <= 1'b1;
      o_dq_t       <= 1'b1;
      o_beat_first <= 1'b0;
      o_beat_last  <= 1'b0;
    end else begin
      state        <= state_d;
      lat_cnt      <= lat_d;
      phase_cnt    <= phase_d;
      beat_cnt     <= beat_d;
      bc4_q        <= bc4_d;
      o_wr_ready   <= ready_d;
      o_busy       <= busy_d;
      o_dqs        <= dqs_d;
      o_dqs_t      <= dqs_t_d;
      o_dq_t       <= dq_t_d;
      o_beat_first <= first_d;
      o_beat_last  <= last_d;
    end
  end

endmodule

// File: tb/tb_ddr3_dqs_tx_ctrl.sv
// tb/tb_ddr3_dqs_tx_ctrl.sv - timeline-model bench for ddr3_dqs_tx_ctrl over three parameter sets
module tb_ddr3_dqs_tx_ctrl;

  localparam int NCFG = 3;
  int lat_p[NCFG]  = '{10, 0, 1};
  int pre_p[NCFG]  = '{2, 2, 3};
  int post_p[NCFG] = '{1, 1, 3};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid = 1'b0;
  logic bc4 = 1'b0;
  logic [NCFG-1:0] ready, dqs, dqs_t, dq_t, first, last, busy;

  int total = 0;
  int bad = 0;

  // k = beats since acceptance (0 idle, -1 just reset and not yet ready)
  int k_m[NCFG];
  int len_m[NCFG];

  always #5 clk = ~clk;

  ddr3_dqs_tx_ctrl #(.WR_LAT_BEATS(10), .PREAMBLE_BEATS(2), .POSTAMBLE_BEATS(1)) dut0 (
    .i_ddr3_clk(clk), .i_rst_n(rst_n), .i_wr_valid(valid), .i_bc4(bc4),
    .o_wr_ready(ready[0]), .o_dqs(dqs[0]), .o_dqs_t(dqs_t[0]), .o_dq_t(dq_t[0]),
    .o_beat_first(first[0]), .o_beat_last(last[0]), .o_busy(busy[0]));

  ddr3_dqs_tx_ctrl #(.WR_LAT_BEATS(0), .PREAMBLE_BEATS(2), .POSTAMBLE_BEATS(1)) dut1 (
    .i_ddr3_clk(clk), .i_rst_n(rst_n), .i_wr_valid(valid), .i_bc4(bc4),
    .o_wr_ready(ready[1]), .o_dqs(dqs[1]), .o_dqs_t(dqs_t[1]), .o_dq_t(dq_t[1]),
    .o_beat_first(first[1]), .o_beat_last(last[1]), .o_busy(busy[1]));

  ddr3_dqs_tx_ctrl #(.WR_LAT_BEATS(1), .PREAMBLE_BEATS(3), .POSTAMBLE_BEATS(3)) dut2 (
    .i_ddr3_clk(clk), .i_rst_n(rst_n), .i_wr_valid(valid), .i_bc4(bc4),
    .o_wr_ready(ready[2]), .o_dqs(dqs[2]), .o_dqs_t(dqs_t[2]), .o_dq_t(dq_t[2]),
    .o_beat_first(first[2]), .o_beat_last(last[2]), .o_busy(busy[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {ready,busy,dqs_t,dqs,dq_t,first,last} from position in the burst timeline
  function automatic logic [6:0] model_out(input int l, input int p, input int q,
                                           input int len, input int k);
    int b;
    if (k < 0)  return 7'b0_0_1_0_1_0_0;
    if (k == 0) return 7'b1_0_1_0_1_0_0;
    if (k <= l) return 7'b0_1_1_0_1_0_0;
    if (k <= l + p) return 7'b0_1_0_0_1_0_0;
    if (k <= l + p + len) begin
      b = k - l - p - 1;
      return {1'b0, 1'b1, 1'b0, (b % 2 == 0), 1'b0, (b == 0), (b == len - 1)};
    end
    return 7'b0_1_0_0_1_0_0;
  endfunction

  function automatic logic [6:0] obs(input int i);
    return {ready[i], busy[i], dqs_t[i], dqs[i], dq_t[i], first[i], last[i]};
  endfunction

  task automatic model_edge();
    for (int i = 0; i < NCFG; i++) begin
      if (k_m[i] < 0) k_m[i] = 0;
      else if (k_m[i] == 0) begin
        if (valid) begin
          k_m[i] = 1;
          len_m[i] = bc4 ? 4 : 8;
        end
      end else if (k_m[i] == lat_p[i] + pre_p[i] + len_m[i] + post_p[i]) k_m[i] = 0;
      else k_m[i] = k_m[i] + 1;
    end
  endtask

  task automatic check_all(input string ph);
    for (int i = 0; i < NCFG; i++) begin
      check($sformatf("%s_cfg%0d_outs", ph, i), 32'(obs(i)),
            32'(model_out(lat_p[i], pre_p[i], post_p[i], len_m[i], k_m[i])));
      check($sformatf("%s_cfg%0d_inv_hiz", ph, i), 32'(dqs_t[i] & dqs[i]), 32'd0);
    end
  endtask

  task automatic cycle(input logic v, input logic b, input string ph);
    @(posedge clk);
    model_edge();
    #1;
    valid = v;
    bc4 = b;
    @(negedge clk);
    check_all(ph);
  endtask

  initial begin
    int n;
    for (int i = 0; i < NCFG; i++) begin
      k_m[i] = -1;
      len_m[i] = 8;
    end
    #12;
    check_all("reset");
    rst_n = 1'b1;

    // BL8 then BC4 single requests, then valid held for back-to-back bursts
    cycle(1'b0, 1'b0, "idle");
    cycle(1'b1, 1'b0, "bl8");
    for (int c = 0; c < 26; c++) cycle(1'b0, 1'b0, "bl8");
    cycle(1'b1, 1'b1, "bc4");
    for (int c = 0; c < 22; c++) cycle(1'b0, 1'b0, "bc4");
    for (int c = 0; c < 60; c++) cycle(1'b1, 1'($urandom_range(0, 1)), "b2b");
    cycle(1'b0, 1'b0, "b2b");
    n = 0;
    while (k_m[0] != 0 && n < 40) begin
      cycle(1'b0, 1'b0, "drain");
      n++;
    end
    check("drain_bound", 32'(k_m[0] == 0), 32'd1);

    // Reset asserted between edges at burst beat 3 of the default-latency instance
    cycle(1'b1, 1'b0, "rst_req");
    n = 0;
    while (k_m[0] != lat_p[0] + pre_p[0] + 4 && n < 40) begin
      cycle(1'b0, 1'b0, "rst_run");
      n++;
    end
    check("rst_beat3_bound", 32'(n < 40), 32'd1);
    check("rst_beat3_dq", 32'(dq_t[0]), 32'd0);
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < NCFG; i++) k_m[i] = -1;
    #1;
    check_all("rst_async");
    @(posedge clk);
    @(negedge clk);
    check_all("rst_held");
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) cycle(1'b0, 1'b0, "post_rst");

    // Random request stream
    for (int c = 0; c < 800; c++)
      cycle(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr3_dqs_tx_ctrl.md
Name: ddr3_dqs_tx_ctrl

Overview:
- Write-strobe sequencer. Drives the I (strobe value) and T (tristate, 1 = hi-Z) inputs of the DQS differential bidirectional buffer, plus the DQ tristate enable.
- For each accepted write burst it runs: write-latency wait, DQS preamble, toggling burst, postamble. It then returns the strobe pins to hi-Z so the read path can use them.
- Sits between the PHY write scheduler and the DQS/DQ IO buffers. One clock cycle equals one data beat (half a DDR3 tCK).

Parameters:
- WR_LAT_BEATS, 10: beats from request acceptance to first preamble beat. Range 0..63.
- PREAMBLE_BEATS, 2: beats DQS is driven low before the first toggle. Range 1..3.
- POSTAMBLE_BEATS, 1: beats DQS is driven low after the last data beat. Range 1..3.

Ports:
- i_ddr3_clk, input, 1: beat-rate clock.
- i_rst_n, input, 1: asynchronous active-low reset.
- i_wr_valid, input, 1: write burst request.
- i_bc4, input, 1: sampled with request. 1 = 4-beat burst (BC4), 0 = 8-beat burst (BL8).
- o_wr_ready, output, 1: request accepted when i_wr_valid & o_wr_ready.
- o_dqs, output, 1: strobe value to the buffer I input.
- o_dqs_t, output, 1: strobe tristate to the buffer T input. 1 = hi-Z.
- o_dq_t, output, 1: DQ tristate. 1 = hi-Z.
- o_beat_first, output, 1: first data beat of burst.
- o_beat_last, output, 1: last data beat of burst.
- o_busy, output, 1: state != IDLE.

Behaviour:
- All outputs are registered. On reset, asynchronously: state=IDLE, o_dqs=0, o_dqs_t=1, o_dq_t=1, o_beat_first=0, o_beat_last=0, o_busy=0, o_wr_ready=0. o_wr_ready rises on the first clock edge after reset deasserts.
- State machine: IDLE, WAIT, PRE, BURST, POST.
- IDLE:
  - o_wr_ready=1. Pins are hi-Z.
  - On accept, latch i_bc4 and go to WAIT with lat_cnt=WR_LAT_BEATS.
  - If WR_LAT_BEATS=0, go directly to PRE.
- WAIT:
  - lat_cnt decrements each cycle.
  - Go to PRE on the cycle lat_cnt reaches 1.
  - Pins remain hi-Z.
- PRE:
  - o_dqs_t=0, o_dqs=0, o_dq_t=1.
  - Lasts PREAMBLE_BEATS cycles, then BURST with beat_cnt=0.
- BURST:
  - o_dqs_t=0, o_dq_t=0, o_dqs = ~beat_cnt[0]. First beat is high (rising edge aligned to first data beat).
  - o_beat_first=1 when beat_cnt=0. o_beat_last=1 when beat_cnt = len-1, where len = 4 for BC4 and 8 for BL8.
  - After the last beat go to POST.
- POST:
  - o_dqs_t=0, o_dqs=0, o_dq_t=1.
  - Lasts POSTAMBLE_BEATS cycles, then IDLE.
- Latency from accept edge to first PRE output cycle is WR_LAT_BEATS+1 cycles. The total busy window is WR_LAT_BEATS + PREAMBLE_BEATS + len + POSTAMBLE_BEATS cycles.
- Strobe-output invariants:
  - o_dqs is always 0 whenever o_dqs_t=1.
  - o_dq_t=0 only in BURST.
  - o_dqs never toggles outside BURST.
- Back-to-back requests: o_wr_ready=0 outside IDLE, so i_wr_valid held during a burst is accepted on the first IDLE cycle. The minimum gap between bursts is therefore one hi-Z cycle. No seamless merging.
- i_bc4 is ignored except at acceptance. A change mid-burst has no effect.
- Reset mid-burst: pins go hi-Z immediately (asynchronously) and the pending burst is discarded.
- Counters:
  - lat_cnt is 6 bits.
  - beat_cnt is 3 bits and never wraps; the FSM exits at len-1.
  - The PRE/POST counter is 2 bits.

Decomposition:
- Shared package ddr3_phy_pkg:
  - state enum.
  - Constants BL8_BEATS=8 and BC4_BEATS=4.
  - Counter widths LAT_CNT_W=6 and PHASE_CNT_W=2.
- No sub-module. Single FSM with three counters, sized for roughly 150–250 lines.

Test Plan:
- Basic BL8, defaults:
  - Stimulus: accept at cycle 0 with i_bc4=0.
  - Response: o_dqs_t falls at cycle 11; o_dqs=0 for cycles 11–12; o_dqs = 1,0,1,0,1,0,1,0 over cycles 13–20.
  - Response: o_dq_t=0 exactly at cycles 13–20; o_beat_first at 13; o_beat_last at 20.
  - Response: POST drives 0 at 21; hi-Z from 22; o_wr_ready=1 at 22.
- BC4:
  - Stimulus: same as BL8 but i_bc4=1.
  - Response: 4 toggling beats at cycles 13–16; o_beat_last at 16; hi-Z from 18.
- Zero latency:
  - Stimulus: WR_LAT_BEATS=0, PREAMBLE_BEATS=2, POSTAMBLE_BEATS=1; accept at 0.
  - Response: PRE at cycles 1–2; burst at 3–10.
- Back-to-back:
  - Stimulus: i_wr_valid held high for two bursts.
  - Response: second accept occurs on the first IDLE cycle; exactly one hi-Z cycle separates the bursts; no DQS toggle outside BURST.
- Reset mid-burst:
  - Stimulus: assert i_rst_n=0 at burst beat 3, asynchronously between clock edges.
  - Response: o_dqs_t=1, o_dq_t=1, o_dqs=0 within the same cycle.
  - Response: after release, o_wr_ready=1 on the next edge and no residual burst appears.
- Invariant checker, run across a random request stream: o_dqs_t=1 implies o_dqs=0; o_dq_t=0 implies state=BURST.
